mem_port_arbiter: RTL and testbench

//  Shares one external memory bus between the fetch stage (instruction reads) and the

---
 rtl/rvcore_bus_pkg.sv | 15 +
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rvcore_bus_pkg.sv
// Shared definitions for the core's external memory bus: command field widths
// and the port arbiter's FSM state encoding.
package rvcore_bus_pkg;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between instruction fetch and the data stage.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter
    import rvcore_bus_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = rvcore_bus_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_vd,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [SW-1:0] dm_wstrb,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_vd,
    output logic          bus_valid,
    input  logic          bus_ready,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [SW-1:0] bus_wstrb,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy,
    output logic          grant_dm
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q,     state_d;
    logic          owner_dm_q,  owner_dm_d;
    logic          cmd_we_q,    cmd_we_d;
    logic [AW-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [SW-1:0] cmd_wstrb_q, cmd_wstrb_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
    logic          if_vd_q,     if_vd_d;
    logic          dm_vd_q,     dm_vd_d;
    logic [CW-1:0] starve_q,    starve_d;

    logic force_if;
    logic dm_win;
    logic if_win;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wstrb_d = cmd_wstrb_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_vd_d     = 1'b0;
        dm_vd_d     = 1'b0;
        starve_d    = starve_q;
        force_if    = 1'b0;
        dm_win      = 1'b0;
        if_win      = 1'b0;

        unique case (state_q)
            IDLE: begin
                force_if = if_req && (starve_q == STARVE_LIM);
                if (dm_req && !force_if) begin
                    dm_win = 1'b1;
                end else if (if_req) begin
                    if_win = 1'b1;
                end

                if (dm_win) begin
                    state_d     = CMD;
                    owner_dm_d  = 1'b1;
                    cmd_we_d    = dm_we;
                    cmd_addr_d  = dm_addr;
                    cmd_wdata_d = dm_wdata;
                    cmd_wstrb_d = dm_we ? dm_wstrb : '0;
                end else if (if_win) begin
                    state_d     = CMD;
                    owner_dm_d  = 1'b0;
                    cmd_we_d    = 1'b0;
                    cmd_addr_d  = if_addr;
                    cmd_wdata_d = '0;
                    cmd_wstrb_d = '0;
                end
            end
            CMD: begin
                if (bus_ready) begin
                    if (cmd_we_q) begin
                        state_d = IDLE;
                        dm_vd_d = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    state_d = IDLE;
                    if (owner_dm_q) begin
                        dm_rdata_d = bus_rdata;
                        dm_vd_d    = 1'b1;
                    end else begin
                        if_rdata_d = bus_rdata;
                        if_vd_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Starvation only accumulates while fetch is actually waiting.
        if (!if_req || if_win) begin
            starve_d = '0;
        end else if (dm_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_vd_q     <= 1'b0;
            dm_vd_q     <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wstrb_q <= cmd_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_vd_q     <= if_vd_d;
            dm_vd_q     <= dm_vd_d;
            starve_q    <= starve_d;
        end
    end

    assign bus_valid = (state_q == CMD);
    assign busy      = (state_q != IDLE);
    assign bus_we    = cmd_we_q;
    assign bus_addr  = cmd_addr_q;
    assign bus_wdata = cmd_wdata_q;
    assign bus_wstrb = cmd_wstrb_q;
    assign grant_dm  = owner_dm_q;
    assign if_rdata  = if_rdata_q;
    assign if_vd     = if_vd_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_vd     = dm_vd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and bus responder,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_vd;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_vd;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        grant_dm;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_vd(if_vd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_vd(dm_vd),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .busy(busy), .grant_dm(grant_dm)
    );

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wd_chk;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked by which bus event it awaits.
    bit          m_cmd_pending;
    bit          m_resp_pending;
    txn_t        cur;
    int          starve;
    bit          e_if_vd, e_dm_vd, e_grant_dm;
    logic [31:0] e_if_rdata, e_dm_rdata;

    // Requester and responder state.
    bit          f_act, d_act;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        d_we;
    logic [3:0]  d_wstrb;

    int p_if, p_dm, p_ready, p_rv, p_stale, p_rst;
    bit force_rst;

    function automatic bit chance(input int pct);
        return ($urandom % 100) < pct;
    endfunction

    task automatic model_reset();
        m_cmd_pending  = 0;
        m_resp_pending = 0;
        cur            = '0;
        cur.wd_chk     = 1'b1;
        starve         = 0;
        e_if_vd        = 0;
        e_dm_vd        = 0;
        e_grant_dm     = 0;
        e_if_rdata     = '0;
        e_dm_rdata     = '0;
    endtask

    task automatic step();
        bit dm_win, if_win;
        @(posedge clk);
        #1;
        check("bus_valid", bus_valid, m_cmd_pending);
        check("busy", busy, m_cmd_pending || m_resp_pending);
        check("grant_dm", grant_dm, e_grant_dm);
        check("if_vd", if_vd, e_if_vd);
        check("dm_vd", dm_vd, e_dm_vd);
        check("if_rdata", if_rdata, e_if_rdata);
        check("dm_rdata", dm_rdata, e_dm_rdata);
        check("bus_addr", bus_addr, cur.addr);
        check("bus_we", bus_we, cur.we);
        check("bus_wstrb", bus_wstrb, cur.we ? cur.wstrb : 4'h0);
        if (cur.wd_chk) check("bus_wdata", bus_wdata, cur.wdata);

        // Requesters retire on completion and may start a fresh request in the same cycle.
        if (e_if_vd) f_act = 0;
        if (e_dm_vd) d_act = 0;
        if (!f_act && chance(p_if)) begin
            f_act  = 1;
            f_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_act && chance(p_dm)) begin
            d_act   = 1;
            d_we    = $urandom_range(0, 1);
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
            d_wstrb = $urandom_range(1, 15);
        end

        rst        = force_rst || (($urandom % 1000) < p_rst);
        if_req     = f_act;
        if_addr    = f_act ? f_addr : $urandom;
        dm_req     = d_act;
        dm_we      = d_act ? d_we : $urandom_range(0, 1);
        dm_addr    = d_act ? d_addr : $urandom;
        dm_wdata   = d_act ? d_wdata : $urandom;
        dm_wstrb   = d_act ? d_wstrb : 4'($urandom);
        bus_ready  = chance(p_ready);
        bus_rvalid = m_resp_pending ? chance(p_rv) : chance(p_stale);
        bus_rdata  = $urandom;

        // Expectations for the next cycle.
        e_if_vd = 0;
        e_dm_vd = 0;
        dm_win  = 0;
        if_win  = 0;
        if (rst) begin
            model_reset();
            f_act = 0;
            d_act = 0;
        end else begin
            if (m_cmd_pending) begin
                if (bus_ready) begin
                    m_cmd_pending = 0;
                    if (cur.we) e_dm_vd = 1;
                    else m_resp_pending = 1;
                end
            end else if (m_resp_pending) begin
                if (bus_rvalid) begin
                    m_resp_pending = 0;
                    if (cur.is_dm) begin
                        e_dm_vd    = 1;
                        e_dm_rdata = bus_rdata;
                    end else begin
                        e_if_vd    = 1;
                        e_if_rdata = bus_rdata;
                    end
                end
            end else begin
                if (dm_req && !(if_req && starve == STARVE_MAX)) dm_win = 1;
                else if (if_req) if_win = 1;
                if (dm_win) begin
                    cur.is_dm  = 1;
                    cur.we     = dm_we;
                    cur.addr   = dm_addr;
                    cur.wdata  = dm_wdata;
                    cur.wstrb  = dm_we ? dm_wstrb : 4'h0;
                    cur.wd_chk = dm_we;
                    e_grant_dm = 1;
                    m_cmd_pending = 1;
                end else if (if_win) begin
                    cur.is_dm  = 0;
                    cur.we     = 0;
                    cur.addr   = if_addr;
                    cur.wdata  = '0;
                    cur.wstrb  = 4'h0;
                    cur.wd_chk = 0;
                    e_grant_dm = 0;
                    m_cmd_pending = 1;
                end
            end
            if (!if_req || if_win) starve = 0;
            else if (dm_win && starve < STARVE_MAX) starve = starve + 1;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
        dm_wdata = '0; dm_wstrb = '0; bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
        f_act = 0; d_act = 0; f_addr = '0; d_addr = '0; d_wdata = '0; d_we = 0; d_wstrb = '0;
        force_rst = 0;
        model_reset();

        // Reset state, then mixed random traffic with slow bus and stale responses.
        p_if = 40; p_dm = 40; p_ready = 60; p_rv = 50; p_stale = 20; p_rst = 0;
        run(1500);

        // Zero-wait bus with both ports permanently requesting: starvation limit.
        p_if = 100; p_dm = 100; p_ready = 100; p_rv = 100; p_stale = 0;
        run(300);

        // Fetch parked in RESP, reset, then stale responses must be ignored.
        p_if = 100; p_dm = 0; p_ready = 100; p_rv = 0; p_stale = 0;
        run(6);
        force_rst = 1;
        run(1);
        force_rst = 0;
        p_if = 0; p_stale = 100;
        run(6);

        // Random traffic including occasional resets.
        p_if = 50; p_dm = 50; p_ready = 50; p_rv = 40; p_stale = 30; p_rst = 5;
        run(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
